// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, FSM state type and round helper functions
package sha256_pkg;

    // Engine sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXPAND   = 2'd1,
        ST_COMPRESS = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Initial hash value loaded into the working registers on reset/restart
    localparam logic [31:0] IV_A = 32'h6a09e667;
    localparam logic [31:0] IV_B = 32'hbb67ae85;
    localparam logic [31:0] IV_C = 32'h3c6ef372;
    localparam logic [31:0] IV_D = 32'ha54ff53a;
    localparam logic [31:0] IV_E = 32'h510e527f;
    localparam logic [31:0] IV_F = 32'h9b05688c;
    localparam logic [31:0] IV_G = 32'h1f83d9ab;
    localparam logic [31:0] IV_H = 32'h5be0cd19;

    // Rotate right by a constant amount (1..31)
    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - combinational single SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_e,
    input  logic [31:0] i_f,
    input  logic [31:0] i_g,
    input  logic [31:0] i_h,
    input  logic [31:0] i_w,
    input  logic [31:0] i_k,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d,
    output logic [31:0] o_e,
    output logic [31:0] o_f,
    output logic [31:0] o_g,
    output logic [31:0] o_h
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    // Round temporaries; all additions wrap modulo 2^32
    always_comb begin
        w_t1 = i_h + big_s1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
        w_t2 = big_s0(i_a) + maj(i_a, i_b, i_c);
    end

    // Shift the register file down one slot, injecting the new a and e
    always_comb begin
        o_a = w_t1 + w_t2;
        o_b = i_a;
        o_c = i_b;
        o_d = i_c;
        o_e = i_d + w_t1;
        o_f = i_e;
        o_g = i_f;
        o_h = i_g;
    end

endmodule

// File: rtl/sha256_round_engine.sv
// rtl/sha256_round_engine.sv - SHA-256 expansion/compression sequencer with working registers
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        restart,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output logic [6:0]  e_count,
    output logic [6:0]  c_count,
    output logic        e_complete,
    output logic        c_complete,
    output logic        busy,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [31:0] d,
    output logic [31:0] e,
    output logic [31:0] f,
    output logic [31:0] g,
    output logic [31:0] h
);

    localparam logic [6:0] LAST_IDX = 7'(NUM_ROUNDS - 1);

    state_t      r_state;
    logic [6:0]  r_e_count;
    logic [6:0]  r_c_count;
    logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [31:0] w_na, w_nb, w_nc, w_nd, w_ne, w_nf, w_ng, w_nh;

    sha256_round u_round (
        .i_a (r_a),
        .i_b (r_b),
        .i_c (r_c),
        .i_d (r_d),
        .i_e (r_e),
        .i_f (r_f),
        .i_g (r_g),
        .i_h (r_h),
        .i_w (w_i),
        .i_k (k_i),
        .o_a (w_na),
        .o_b (w_nb),
        .o_c (w_nc),
        .o_d (w_nd),
        .o_e (w_ne),
        .o_f (w_nf),
        .o_g (w_ng),
        .o_h (w_nh)
    );

    // Sequencer: reset beats restart, restart beats everything else; rounds only in COMPRESS
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state   <= ST_IDLE;
            r_e_count <= 7'd0;
            r_c_count <= 7'd0;
            r_a <= IV_A; r_b <= IV_B; r_c <= IV_C; r_d <= IV_D;
            r_e <= IV_E; r_f <= IV_F; r_g <= IV_G; r_h <= IV_H;
        end else if (restart) begin
            r_state   <= ST_EXPAND;
            r_e_count <= 7'd0;
            r_c_count <= 7'd0;
            r_a <= IV_A; r_b <= IV_B; r_c <= IV_C; r_d <= IV_D;
            r_e <= IV_E; r_f <= IV_F; r_g <= IV_G; r_h <= IV_H;
        end else begin
            case (r_state)
                ST_EXPAND: begin
                    if (r_e_count == LAST_IDX) begin
                        r_state   <= ST_COMPRESS;
                        r_c_count <= 7'd0;
                    end else begin
                        r_e_count <= r_e_count + 7'd1;
                    end
                end
                ST_COMPRESS: begin
                    r_a <= w_na; r_b <= w_nb; r_c <= w_nc; r_d <= w_nd;
                    r_e <= w_ne; r_f <= w_nf; r_g <= w_ng; r_h <= w_nh;
                    if (r_c_count == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_c_count <= r_c_count + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags decode directly from registered state and counters
    always_comb begin
        busy       = (r_state == ST_EXPAND) || (r_state == ST_COMPRESS);
        e_complete = (r_state == ST_EXPAND) && (r_e_count == LAST_IDX);
        c_complete = (r_state == ST_DONE);
        e_count    = r_e_count;
        c_count    = r_c_count;
        a = r_a; b = r_b; c = r_c; d = r_d;
        e = r_e; f = r_f; g = r_g; h = r_h;
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb/tb_sha256_round_engine.sv - self-checking bench for sha256_round_engine
module tb_sha256_round_engine;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        restart;
    logic [31:0] w_i, k_i;
    logic [6:0]  e_count, c_count;
    logic        e_complete, c_complete, busy;
    logic [31:0] a, b, c, d, e, f, g, h;

    int errors = 0;
    int checks = 0;

    logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    logic [31:0] abc_digest [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    logic [31:0] round0_exp [8] = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};

    logic [31:0] wt [64];
    logic [31:0] kt [64];
    logic [31:0] ref_out [8];
    logic [31:0] snap [8];

    sha256_round_engine #(.NUM_ROUNDS(64)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .restart    (restart),
        .w_i        (w_i),
        .k_i        (k_i),
        .e_count    (e_count),
        .c_count    (c_count),
        .e_complete (e_complete),
        .c_complete (c_complete),
        .busy       (busy),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g), .h (h)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_regs(output logic [31:0] r [8]);
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] exp [8]);
        logic [31:0] cur [8];
        get_regs(cur);
        for (int i = 0; i < 8; i++) check($sformatf("%s[%0d]", tag, i), cur[i], exp[i]);
    endtask

    // Straightforward SHA-256 compression of one block from the IV using wt/kt
    task automatic ref_compress();
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 8; i++) v[i] = iv[i];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[r] + wt[r];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) ref_out[i] = v[i];
    endtask

    task automatic load_abc();
        for (int t = 0; t < 16; t++) wt[t] = 32'd0;
        wt[0]  = 32'h61626380;
        wt[15] = 32'h00000018;
        for (int t = 16; t < 64; t++)
            wt[t] = (ror(wt[t-2], 17) ^ ror(wt[t-2], 19) ^ (wt[t-2] >> 10)) + wt[t-7]
                  + (ror(wt[t-15], 7) ^ ror(wt[t-15], 18) ^ (wt[t-15] >> 3)) + wt[t-16];
        for (int t = 0; t < 64; t++) kt[t] = ktab[t];
    endtask

    // Restart pulse then the 64 expansion cycles, ending with c_count=0 in COMPRESS
    task automatic expand_phase();
        restart = 1'b1;
        w_i = $urandom; k_i = $urandom;
        tick();
        restart = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_e_count", 32'(e_count), 32'd0);
        check("start_c_count", 32'(c_count), 32'd0);
        check_regs("start_iv", iv);
        for (int i = 1; i < 64; i++) begin
            w_i = $urandom; k_i = $urandom;
            tick();
            check("e_count", 32'(e_count), 32'(i));
            check("e_complete", 32'(e_complete), 32'(i == 63));
        end
        check_regs("expand_iv", iv);
        tick();
        check("compress_c_count0", 32'(c_count), 32'd0);
        check("compress_e_count", 32'(e_count), 32'd63);
        check("compress_e_complete", 32'(e_complete), 32'd0);
        check("compress_busy", 32'(busy), 32'd1);
    endtask

    task automatic compress_phase(input int lo, input int hi);
        for (int r = lo; r < hi; r++) begin
            check("c_count", 32'(c_count), 32'(r));
            w_i = wt[r]; k_i = kt[r];
            tick();
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_c_complete"}, 32'(c_complete), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_c_count"}, 32'(c_count), 32'd63);
        check({tag, "_e_count"}, 32'(e_count), 32'd63);
        check_regs({tag, "_regs"}, ref_out);
    endtask

    initial begin
        n_rst = 1'b1; restart = 1'b0; w_i = '0; k_i = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_e_count", 32'(e_count), 32'd0);
        check("rst_c_count", 32'(c_count), 32'd0);
        check("rst_e_complete", 32'(e_complete), 32'd0);
        check("rst_c_complete", 32'(c_complete), 32'd0);
        check_regs("rst_iv", iv);
        tick(); tick();
        n_rst = 1'b0;

        // IDLE: random inputs must not start rounds
        for (int i = 0; i < 5; i++) begin
            w_i = $urandom; k_i = $urandom;
            tick();
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_c_complete", 32'(c_complete), 32'd0);
        check_regs("idle_iv", iv);

        // "abc" block: round 0 then full digest
        load_abc();
        ref_compress();
        expand_phase();
        compress_phase(0, 1);
        check_regs("round0", round0_exp);
        compress_phase(1, 64);
        check_done("abc_done");
        get_regs(snap);
        for (int i = 0; i < 8; i++)
            check($sformatf("abc_digest[%0d]", i), snap[i] + iv[i], abc_digest[i]);

        // DONE hold with toggling inputs
        for (int i = 0; i < 20; i++) begin
            w_i = $urandom; k_i = $urandom;
            tick();
        end
        check_done("hold");

        // Restart mid-compression, then a clean rerun
        expand_phase();
        compress_phase(0, 30);
        check("pre_restart_c_count", 32'(c_count), 32'd30);
        expand_phase();
        compress_phase(0, 64);
        check_done("rerun");

        // Random schedule and constants against the reference model
        for (int blk = 0; blk < 2; blk++) begin
            for (int t = 0; t < 64; t++) begin
                wt[t] = $urandom; kt[t] = $urandom;
            end
            ref_compress();
            expand_phase();
            compress_phase(0, 64);
            check_done($sformatf("rand%0d", blk));
        end

        // Asynchronous reset in the middle of COMPRESS
        load_abc();
        expand_phase();
        compress_phase(0, 10);
        #3 n_rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_e_count", 32'(e_count), 32'd0);
        check("arst_c_count", 32'(c_count), 32'd0);
        check("arst_c_complete", 32'(c_complete), 32'd0);
        check_regs("arst_iv", iv);
        restart = 1'b1;
        tick();
        check("arst_priority_busy", 32'(busy), 32'd0);
        restart = 1'b0;
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_i = $urandom; k_i = $urandom;
            tick();
        end
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_e_count", 32'(e_count), 32'd0);
        check_regs("post_rst_iv", iv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 Parameter: NUM_ROUNDS, default 64, number of expansion steps and of compression rounds; only 64 is required to work.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  asynchronous reset, active-high (1 = reset asserted).
REQ-004 restart  input  1  start request, sampled on clk edge.
REQ-005 w_i  input  32  message-schedule word for the current compression index (c_count).
REQ-006 k_i  input  32  round constant for the current compression index (c_count).
REQ-007 e_count  output  7  expansion-phase index.
REQ-008 c_count  output  7  compression-phase index; the environment uses it to select w_i and k_i.
REQ-009 e_complete  output  1  high while the last expansion step is active.
REQ-010 c_complete  output  1  high while all rounds are finished (DONE).
REQ-011 busy  output  1  high in EXPAND or COMPRESS.
REQ-012 a, b, c, d, e, f, g, h  output  32 each  working registers.

Function
REQ-013 FSM states: IDLE, EXPAND, COMPRESS, DONE; busy = (EXPAND or COMPRESS).
REQ-014 restart=1 at any edge, in any state (including mid-operation): next state EXPAND, e_count=0, c_count=0, a..h reloaded with the IV.
REQ-015 IV: a=6a09e667, b=bb67ae85, c=3c6ef372, d=a54ff53a, e=510e527f, f=9b05688c, g=1f83d9ab, h=5be0cd19.
REQ-016 EXPAND: e_count increments by 1 per edge, 0..63; e_complete = EXPAND and e_count==63 (combinational, one cycle).
REQ-017 EXPAND with e_count==63 and no restart: next state COMPRESS, c_count=0; e_count holds 63.
REQ-018 COMPRESS: each edge performs one round using w_i and k_i presented while c_count=r, then c_count increments.
REQ-019 Round, all sums mod 2^32: S1=ROTR6(e)^ROTR11(e)^ROTR25(e); ch=(e&f)^(~e&g); T1=h+S1+ch+k_i+w_i; S0=ROTR2(a)^ROTR13(a)^ROTR22(a); maj=(a&b)^(a&c)^(b&c); T2=S0+maj.
REQ-020 Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-021 COMPRESS with c_count==63: round 63 executes, next state DONE, c_count holds 63.
REQ-022 DONE: a..h, e_count, c_count hold; c_complete=1; remain until restart.
REQ-023 IDLE: registers hold; no rounds execute; c_complete=0, e_complete=0.
REQ-024 Timing: restart sampled at edge E0; c_count=0 after E64; DONE after E128.
REQ-025 Working registers change only on a round or on restart/reset.

Reset
REQ-026 n_rst=1 forces asynchronously: state IDLE, e_count=0, c_count=0, busy=0, e_complete=0, c_complete=0, a..h=IV.
REQ-027 Reset has priority over restart; operation begins only on a restart sampled after n_rst deasserts.

Structure
REQ-028 Shared package sha256_pkg holds: IV constants, FSM state enum, ROTR, S0/S1/ch/maj functions.
REQ-029 One combinational sub-module, sha256_round, maps (a..h, w_i, k_i) to next a..h; counters and FSM live in the top.

Verification
REQ-030 Reset: assert n_rst mid-COMPRESS -> immediately IDLE, counts 0, a..h=IV, busy=0.
REQ-031 Sequencing: restart pulse -> e_complete high exactly when e_count=63 (cycle 64); c_count=0 next cycle; c_complete=1 after 128 edges.
REQ-032 Round 0, "abc" block: w_i=61626380, k_i=428a2f98 -> a=5d6aebcd, b=6a09e667, c=bb67ae85, d=3c6ef372, e=fa2a4622, f=510e527f, g=9b05688c, h=1f83d9ab.
REQ-033 Full "abc" schedule with FIPS-180 constants -> a+6a09e667 = ba7816bf (a=506e3058); a..h+IV = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 Restart at c_count=30 -> EXPAND, e_count=0, a..h=IV; subsequent run yields the same "abc" result.
REQ-035 DONE hold: w_i/k_i toggled randomly for 20 cycles after completion -> a..h unchanged, c_complete stays 1.
